// File: rtl/shared_and_sched_if.sv
// rtl/shared_and_sched_if.sv - request/result handshake bundle for shared_and_sched
//
// Groups the requester side (req_valid/req_data/req_ready) and the result side
// (res_valid/res_ready/res_id/res_y) of the scheduler.
//   master : requesting logic / result consumer
//   slave  : the scheduler itself
interface shared_and_sched_if #(
    parameter int NREQ = 4,
    parameter int W    = 3,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              res_valid;
    logic              res_ready;
    logic [IDW-1:0]    res_id;
    logic              res_y;

    modport master (
        output req_valid, req_data, res_ready,
        input  req_ready, res_valid, res_id, res_y
    );

    modport slave (
        input  req_valid, req_data, res_ready,
        output req_ready, res_valid, res_id, res_y
    );
endinterface

// File: rtl/shared_and_sched.sv
// rtl/shared_and_sched.sv - round-robin scheduler sharing one external AND2 cell
//
// Each granted requester's W-bit operand vector is AND-reduced serially through
// the single shared AND2 (and_a/and_b -> and_y), one operand per cycle, and the
// result is returned tagged with the requester index.
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   bus          : slave side of shared_and_sched_if (requests in, results out)
//   and_a, and_b : operands driven to the shared AND2, 0 outside STEP
//   and_y        : combinational result of the shared AND2
//   busy         : high whenever the block is not idle
module shared_and_sched #(
    parameter int NREQ = 4,
    parameter int W    = 3,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shared_and_sched_if.slave    bus,
    output logic                 and_a,
    output logic                 and_b,
    input  logic                 and_y,
    output logic                 busy
);

    // cnt has to hold W after the final STEP increment
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STEP,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [IDW-1:0]    ptr;
    logic [IDW-1:0]    owner;
    logic [W-1:0]      op;
    logic              acc;
    logic [CW-1:0]     cnt;

    logic              found;
    logic [IDW-1:0]    winner;
    logic [IDW-1:0]    idx;
    logic [NREQ*W-1:0] data_sh;
    logic [W-1:0]      win_data;
    logic [W-1:0]      op_sh;
    logic              grant;

    // Round-robin search starting one past the last winner.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (!found && bus.req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Shift rather than part-select so the winner index width never matters.
    always_comb begin
        data_sh  = bus.req_data >> (32'(winner) * 32'(W));
        win_data = data_sh[W-1:0];
    end

    assign grant = (state == S_IDLE) && found;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (found) begin
                    state_nxt = (W == 1) ? S_DONE : S_STEP;
                end
            end
            S_STEP: begin
                if (cnt == CW'(W - 1)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.res_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            ptr   <= IDW'(NREQ - 1);
            owner <= '0;
            op    <= '0;
            acc   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                // Operand 0 seeds the accumulator, so the chain starts at op[1].
                op    <= win_data;
                acc   <= win_data[0];
                cnt   <= CW'(1);
                owner <= winner;
                ptr   <= winner;
            end else if (state == S_STEP) begin
                acc <= and_y;
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign op_sh = op >> cnt;

    // All outputs decode from the state register so an asynchronous reset
    // returns them to their idle values immediately.
    assign bus.req_ready = grant ? (NREQ'(1) << winner) : '0;
    assign and_a         = (state == S_STEP) ? acc : 1'b0;
    assign and_b         = (state == S_STEP) ? op_sh[0] : 1'b0;
    assign bus.res_valid = (state == S_DONE);
    assign bus.res_id    = (state == S_DONE) ? owner : '0;
    assign bus.res_y     = (state == S_DONE) ? acc : 1'b0;
    assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_shared_and_sched.sv
// tb/tb_shared_and_sched.sv - directed self-checking bench for shared_and_sched
module tb_shared_and_sched;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    shared_and_sched_if #(.NREQ(4), .W(3)) bus3 ();
    shared_and_sched_if #(.NREQ(4), .W(1)) bus1 ();

    logic a3, b3, y3, busy3;
    logic a1, b1, y1, busy1;

    // The shared AND2 cells
    assign y3 = a3 & b3;
    assign y1 = a1 & b1;

    shared_and_sched #(.NREQ(4), .W(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3),
        .and_a (a3),
        .and_b (b3),
        .and_y (y3),
        .busy  (busy3)
    );

    shared_and_sched #(.NREQ(4), .W(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1),
        .and_a (a1),
        .and_b (b1),
        .and_y (y1),
        .busy  (busy1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus3.req_valid = '0;
        bus3.req_data  = '0;
        bus3.res_ready = 1'b1;
        bus1.req_valid = '0;
        bus1.req_data  = '0;
        bus1.res_ready = 1'b1;
        tick();
        tick();

        // reset state
        check("rst_rr",    32'(bus3.req_ready), 32'h0);
        check("rst_rv",    32'(bus3.res_valid), 32'h0);
        check("rst_id",    32'(bus3.res_id),    32'h0);
        check("rst_y",     32'(bus3.res_y),     32'h0);
        check("rst_a",     32'(a3),             32'h0);
        check("rst_b",     32'(b3),             32'h0);
        check("rst_busy",  32'(busy3),          32'h0);
        check("rst_busy1", 32'(busy1),          32'h0);
        rst_n = 1'b1;
        tick();

        // requester 0, data 111
        bus3.req_data  = 12'b000_000_000_111;
        bus3.req_valid = 4'b0001;
        #1;
        check("t1_rr_c0",   32'(bus3.req_ready), 32'h1);
        check("t1_busy_c0", 32'(busy3),          32'h0);
        tick();
        bus3.req_valid = 4'b0000;
        #1;
        check("t1_busy_c1", 32'(busy3),          32'h1);
        check("t1_rr_c1",   32'(bus3.req_ready), 32'h0);
        check("t1_a_c1",    32'(a3),             32'h1);
        check("t1_b_c1",    32'(b3),             32'h1);
        tick();
        check("t1_busy_c2", 32'(busy3),          32'h1);
        check("t1_rv_c2",   32'(bus3.res_valid), 32'h0);
        tick();
        check("t1_rv_c3",   32'(bus3.res_valid), 32'h1);
        check("t1_id_c3",   32'(bus3.res_id),    32'h0);
        check("t1_y_c3",    32'(bus3.res_y),     32'h1);
        check("t1_busy_c3", 32'(busy3),          32'h1);
        tick();
        check("t1_rv_c4",   32'(bus3.res_valid), 32'h0);
        check("t1_busy_c4", 32'(busy3),          32'h0);

        // requester 2, data 101; req_data changed after grant must not matter
        bus3.req_data  = 12'b000_101_000_000;
        bus3.req_valid = 4'b0100;
        #1;
        check("t2_rr_c0", 32'(bus3.req_ready), 32'h4);
        tick();
        bus3.req_valid = 4'b0000;
        bus3.req_data  = 12'hFFF;
        #1;
        check("t2_a_c1", 32'(a3), 32'h1);
        check("t2_b_c1", 32'(b3), 32'h0);
        tick();
        check("t2_a_c2", 32'(a3), 32'h0);
        check("t2_b_c2", 32'(b3), 32'h1);
        tick();
        check("t2_rv_c3", 32'(bus3.res_valid), 32'h1);
        check("t2_id_c3", 32'(bus3.res_id),    32'h2);
        check("t2_y_c3",  32'(bus3.res_y),     32'h0);
        tick();

        // all requesters pending from reset: order 0,1,2,3,0, 4 cycles apart
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        bus3.req_data  = 12'hFFF;
        bus3.req_valid = 4'hF;
        #1;
        for (int g = 0; g < 5; g++) begin
            check($sformatf("t3_rr_g%0d", g), 32'(bus3.req_ready), 32'(1 << (g % 4)));
            tick();
            if (g == 4) bus3.req_valid = 4'h0;
            tick();
            tick();
            check($sformatf("t3_rv_g%0d", g), 32'(bus3.res_valid), 32'h1);
            check($sformatf("t3_id_g%0d", g), 32'(bus3.res_id),    32'(g % 4));
            tick();
        end
        check("t3_idle", 32'(busy3), 32'h0);

        // back-pressure: res_ready low for 5 cycles, requester 3 waiting
        bus3.req_data  = 12'b011_000_111_000;
        bus3.req_valid = 4'b0010;
        bus3.res_ready = 1'b0;
        #1;
        check("t4_rr_c0", 32'(bus3.req_ready), 32'h2);
        tick();
        bus3.req_valid = 4'b1000;
        #1;
        check("t4_rr_c1", 32'(bus3.req_ready), 32'h0);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t4_rv_h%0d", i), 32'(bus3.res_valid), 32'h1);
            check($sformatf("t4_id_h%0d", i), 32'(bus3.res_id),    32'h1);
            check($sformatf("t4_y_h%0d", i),  32'(bus3.res_y),     32'h1);
            check($sformatf("t4_rr_h%0d", i), 32'(bus3.req_ready), 32'h0);
            tick();
        end
        bus3.res_ready = 1'b1;
        #1;
        check("t4_rv_hs", 32'(bus3.res_valid), 32'h1);
        check("t4_rr_hs", 32'(bus3.req_ready), 32'h0);
        tick();
        check("t4_rr_next", 32'(bus3.req_ready), 32'h8);
        check("t4_rv_next", 32'(bus3.res_valid), 32'h0);
        tick();
        bus3.req_valid = 4'b0000;
        tick();
        tick();
        check("t4_rv_r3", 32'(bus3.res_valid), 32'h1);
        check("t4_id_r3", 32'(bus3.res_id),    32'h3);
        check("t4_y_r3",  32'(bus3.res_y),     32'h0);
        tick();

        // reset in STEP cycle 1 aborts the operation
        bus3.req_data  = 12'hFFF;
        bus3.req_valid = 4'b0100;
        #1;
        check("t5_rr_c0", 32'(bus3.req_ready), 32'h4);
        tick();
        bus3.req_valid = 4'b0000;
        #1;
        check("t5_busy_c1", 32'(busy3), 32'h1);
        rst_n = 1'b0;
        #1;
        check("t5_busy_rst", 32'(busy3),          32'h0);
        check("t5_a_rst",    32'(a3),             32'h0);
        check("t5_b_rst",    32'(b3),             32'h0);
        check("t5_rv_rst",   32'(bus3.res_valid), 32'h0);
        check("t5_rr_rst",   32'(bus3.req_ready), 32'h0);
        check("t5_id_rst",   32'(bus3.res_id),    32'h0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t5_norv_%0d", i), 32'(bus3.res_valid), 32'h0);
        end
        bus3.req_valid = 4'hF;
        #1;
        check("t5_rr_after", 32'(bus3.req_ready), 32'h1);
        tick();
        bus3.req_valid = 4'h0;
        tick();
        tick();
        check("t5_rv_after", 32'(bus3.res_valid), 32'h1);
        check("t5_id_after", 32'(bus3.res_id),    32'h0);
        tick();

        // W==1 instance: requester 3, data 1
        bus1.req_data  = 4'b1000;
        bus1.req_valid = 4'b1000;
        #1;
        check("t6_rr_c0", 32'(bus1.req_ready), 32'h8);
        check("t6_a_c0",  32'(a1),             32'h0);
        check("t6_b_c0",  32'(b1),             32'h0);
        tick();
        bus1.req_valid = 4'b0000;
        #1;
        check("t6_rv_c1", 32'(bus1.res_valid), 32'h1);
        check("t6_id_c1", 32'(bus1.res_id),    32'h3);
        check("t6_y_c1",  32'(bus1.res_y),     32'h1);
        check("t6_a_c1",  32'(a1),             32'h0);
        check("t6_b_c1",  32'(b1),             32'h0);
        tick();
        check("t6_rv_c2",   32'(bus1.res_valid), 32'h0);
        check("t6_busy_c2", 32'(busy1),          32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shared_and_sched.md
# shared_and_sched

Round-robin scheduler that shares one external 2-input AND cell among NREQ requesters. Each requester submits a W-bit operand vector. The block AND-reduces that vector serially through the shared cell, one operand per cycle, the same way a 3-input AND is built by chaining two 2-input ANDs. It sits between the requesting logic and the single shared AND2 instance, and returns each reduction result tagged with the requester index.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 3, operands per request (1..16)
- IDW, $clog2(NREQ), width of the requester index

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  request pending, one bit per requester
- req_data  in  NREQ*W  operand vectors; requester i uses bits [i*W +: W]
- req_ready  out  NREQ  one-hot grant; the handshake completes on the edge where req_valid[i] & req_ready[i]
- and_a  out  1  operand A to the shared AND2
- and_b  out  1  operand B to the shared AND2
- and_y  in  1  result from the shared AND2 (combinational, and_a & and_b)
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts the result
- res_id  out  IDW  index of the requester that owns the result
- res_y  out  1  AND of all W operand bits
- busy  out  1  high in every state except IDLE

## Operation
- FSM states:
  - IDLE: if any req_valid bit is set, grant one requester and go to STEP. If W==1, go straight to DONE.
  - STEP: each cycle, and_a = acc and and_b = op[cnt]; on the edge, acc <= and_y and cnt <= cnt+1. After W-1 STEP cycles (cnt == W-1 sampled), go to DONE.
  - DONE: res_valid=1 with res_y=acc and res_id=owner. Stay until res_valid & res_ready, then go to IDLE.
- Arbitration, IDLE only:
  - Search starts at index ptr+1 modulo NREQ; the first set req_valid wins.
  - req_ready is asserted combinationally for that one requester only, and is 0 in every other state.
  - On the grant edge: op <= the winner's req_data slice, acc <= op bit 0, cnt <= 1, owner <= winner, ptr <= winner.
- ptr resets to NREQ-1, so requester 0 has first priority after reset.
- Outside STEP, and_a and and_b are driven to 0.
- The result depends only on data captured at the grant edge. Later changes to req_data have no effect.
- The block never takes a new grant while in STEP or DONE. Pending requests wait.
- A requester that drops req_valid before it is granted is not served, and no error is flagged.

## Timing
- Reset (async assert, sync deassert by the system) puts the block in:
  - state IDLE;
  - req_ready=0, res_valid=0, res_id=0, res_y=0;
  - and_a=0, and_b=0, busy=0;
  - ptr=NREQ-1, acc=0, cnt=0.
- Grant edge = cycle 0.
  - STEP occupies cycles 1..W-1.
  - res_valid rises in cycle W; for W==1, in cycle 1.
- Minimum time from one grant to the next is W+1 cycles, which requires res_ready held high.
- With res_ready already high when res_valid rises: one-cycle res_valid pulse, and IDLE on the next edge.
- Reset asserted mid-STEP or in DONE: the operation is aborted, no result is produced, and every output returns to its reset value immediately.
- res_ready while res_valid is 0 is ignored.
- The simultaneous arrival of a new req_valid and the DONE handshake is not granted in that cycle. It is granted in the following IDLE cycle.

## Test plan
- Reset, then req_valid=0001 and req_data[2:0]=3'b111, res_ready tied 1 -> req_ready=0001 in cycle 0; res_valid=1 in cycle 3 with res_id=0 and res_y=1; busy high in cycles 1..3.
- Requester 2 with data 3'b101 -> in STEP cycle 2, and_a=0 and and_b=1; result res_id=2, res_y=0.
- All four req_valid held high, all data 3'b111 -> grants in the order 0,1,2,3,0, each 4 cycles apart.
- res_ready held 0 for 5 cycles after res_valid rises -> res_valid, res_id and res_y stay stable; no req_ready is asserted; the grant comes the cycle after the handshake.
- rst_n pulsed low in STEP cycle 1 -> all outputs at reset values immediately; no res_valid; the next grant goes to requester 0.
- Rebuild with W=1, requester 3 with data 1'b1 -> res_valid in cycle 1, res_y=1, res_id=3, and and_a/and_b stay 0 throughout.
